// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch PC, request credits, in-order response queue, redirect drain (optional FETCH_BYPASS_EN)
module inst_fetch_queue #(
  parameter int              PC_W     = 9,
  parameter int              IW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [IW-1:0]   imem_rsp_data,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic [IW-1:0]   out_inst
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [PC_W-1:0] q_pc   [DEPTH];
  logic [IW-1:0]   q_inst [DEPTH];

  logic run_mode;
  logic credit_ok;
  logic req_fire;
  logic rsp_live;
  logic q_nonempty;
  logic bypass;
  logic byp_take;
  logic push;
  logic pop;

  // Outstanding requests plus buffered entries never exceed DEPTH, so every
  // live response is guaranteed a slot.
  assign run_mode   = (drop_q == '0);
  assign credit_ok  = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_X;
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire   = imem_req_valid && imem_req_ready;
  assign rsp_live   = imem_rsp_valid && run_mode && !redirect_valid;
  assign q_nonempty = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_live && !q_nonempty;
`else
  assign bypass = 1'b0;
`endif

  assign byp_take = bypass && !stall;
  assign push     = rsp_live && !byp_take;
  assign pop      = q_nonempty && !redirect_valid && !stall;

  // Present the queue head, or the arriving response when bypassing an empty queue.
  always_comb begin
    out_valid = !redirect_valid && (q_nonempty || bypass);
    out_pc    = '0;
    out_inst  = '0;
    if (out_valid) begin
      if (q_nonempty) begin
        out_pc   = q_pc[head_q];
        out_inst = q_inst[head_q];
      end else begin
        out_pc   = rsp_pc_q;
        out_inst = imem_rsp_data;
      end
    end
  end

  // Next-state for PCs, counters and queue pointers; redirect overrides all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      count_d    = '0;
      drop_d     = inflight_q - CW'(imem_rsp_valid);
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_W'(1);
      if (rsp_live) rsp_pc_d = rsp_pc_q + PC_W'(1);
      if (imem_rsp_valid && !run_mode) drop_d = drop_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue payload storage; contents are only observed when count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail_q]   <= rsp_pc_q;
      q_inst[tail_q] <= imem_rsp_data;
    end
  end

  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight_q != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (count_q != DEPTH_C));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int PC_W = 9;
  localparam int IW   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            stall;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [IW-1:0]   imem_rsp_data;
  logic            out_valid;
  logic [PC_W-1:0] out_pc;
  logic [IW-1:0]   out_inst;

  int checks = 0;
  int errors = 0;
  int cyc;
  int lat;
  int nseen;
  logic [PC_W-1:0] exp_pc;

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
  } req_t;
  req_t pend[$];

  inst_fetch_queue #(.PC_W(PC_W), .IW(IW), .DEPTH(4), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; in-order memory model returns inst = addr + 0x100 after lat cycles.
  task automatic tick();
    req_t r;
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst_n) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {23'b0, pend[0].addr} + 32'h100;
      pend.delete(0);
    end
  endtask

  // Run n cycles, checking every presented instruction against the expected sequence.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      if (out_valid) begin
        chk("seq_pc", 32'(out_pc), 32'(exp_pc));
        chk("seq_inst", out_inst, {23'b0, exp_pc} + 32'h100);
        nseen++;
        if (!stall) exp_pc = exp_pc + 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    lat            = 1;
    cyc            = 0;
    nseen          = 0;
    exp_pc         = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);

    // First request right after reset release
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", 32'(imem_req_addr), 32'd0);
    tick();
    #1;
`ifdef FETCH_BYPASS_EN
    chk("bypass_same_cycle_valid", 32'(out_valid), 32'd1);
`else
    chk("registered_no_valid_yet", 32'(out_valid), 32'd0);
    tick();
    #1;
    chk("registered_valid_next", 32'(out_valid), 32'd1);
`endif
    run(2);

    // Stall 6 cycles at pc 2: output holds, credits run out
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", 32'(out_pc), 32'd2);
      if (i == 5) chk("stall_req_dropped", 32'(imem_req_valid), 32'd0);
      tick();
    end
    stall = 1'b0;
    nseen = 0;
    run(5);
    chk("release_count", 32'(nseen), 32'd5);
    chk("release_next_pc", 32'(exp_pc), 32'd7);

    // Drain everything, then 3 requests in flight at latency 3, then redirect
    imem_req_ready = 1'b0;
    lat = 3;
    run(8);
    #1;
    chk("drained_empty", 32'(out_valid), 32'd0);
    imem_req_ready = 1'b1;
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 9'h040;
    #1;
    chk("redir_out_valid", 32'(out_valid), 32'd0);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("post_redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_redir_req_addr", 32'(imem_req_addr), 32'h040);
    exp_pc = 9'h040;
    nseen  = 0;
    run(12);
    chk("redir_presented", 32'(nseen >= 3), 32'd1);

    // Redirect coinciding with a response and a stall, target near PC wrap
    lat = 1;
    run(10);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h1FE;
    #1;
    chk("redir_rsp_valid_gate", 32'(out_valid), 32'd0);
    chk("redir_rsp_req_gate", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wrap_req_addr", 32'(imem_req_addr), 32'h1FE);
    exp_pc = 9'h1FE;
    nseen  = 0;
    run(8);
`ifdef FETCH_BYPASS_EN
    chk("wrap_end_pc", 32'(exp_pc), 32'h005);
`else
    chk("wrap_end_pc", 32'(exp_pc), 32'h004);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
